// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, opcode/func constants, select encodings and decoded instruction class
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [1:0] A3_RT   = 2'b00;
  localparam logic [1:0] A3_RD   = 2'b01;
  localparam logic [1:0] A3_RA   = 2'b10;
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DM   = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jr;
    logic jal;
    logic nop;
  } cls_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps IR op/func onto a one-hot instruction class; anything unrecognised becomes nop
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output cls_t       cls_o
);
  logic r;
  assign r = op_i == OP_R;
  always_comb begin
    cls_o      = '0;
    cls_o.addu = r && func_i == FN_ADDU;
    cls_o.subu = r && func_i == FN_SUBU;
    cls_o.jr   = r && func_i == FN_JR;
    cls_o.ori  = op_i == OP_ORI;
    cls_o.lui  = op_i == OP_LUI;
    cls_o.lw   = op_i == OP_LW;
    cls_o.sw   = op_i == OP_SW;
    cls_o.beq  = op_i == OP_BEQ;
    cls_o.j    = op_i == OP_J;
    cls_o.jal  = op_i == OP_JAL;
    cls_o.nop  = ~|cls_o[10:1];
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with DM req/ack handshake, MEM timeout and retire counter
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             mem_ack,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alur_we,
  output logic             pc_we,
  output logic [1:0]       npc_op,
  output logic [2:0]       alu_ctrl,
  output logic             ext_op,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mgrf_a3,
  output logic [1:0]       mgrf_wd,
  output logic             malub,
  output logic             mem_err,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int WW = $clog2(MEM_TO + 1);
  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout, sel_v;
  cls_t             cls;
  mc_decode u_dec (.op_i(op), .func_i(func), .cls_o(cls));
  assign timeout    = wcnt_q == WW'(MEM_TO);
  assign state      = state_q;
  assign mem_err    = err_q;
  assign retire_cnt = cnt_q;
  // IR is only meaningful from DECODE on, so selects stay 0 in FETCH and illegal states
  assign sel_v    = state_q inside {S_DECODE, S_EXE, S_MEM, S_WB};
  assign alu_ctrl = !sel_v ? ALU_ADD : (cls.subu | cls.beq) ? ALU_SUB : cls.ori ? ALU_OR : cls.lui ? ALU_LUI : ALU_ADD;
  assign ext_op   = sel_v & (cls.lw | cls.sw);
  assign malub    = sel_v & (cls.ori | cls.lui | cls.lw | cls.sw);
  assign mgrf_a3  = !sel_v ? A3_RT : (cls.addu | cls.subu) ? A3_RD : cls.jal ? A3_RA : A3_RT;
  assign mgrf_wd  = !sel_v ? WD_ALU : cls.lw ? WD_DM : cls.jal ? WD_PC4 : WD_ALU;
  always_comb begin
    state_d   = S_FETCH;
    wcnt_d    = '0;
    err_d     = err_q;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    alur_we   = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    npc_op    = NPC_PC4;
    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ab_we   = 1'b1;
        pc_we   = cls.j | cls.jr | cls.nop;
        npc_op  = cls.j ? NPC_J : cls.jr ? NPC_JR : NPC_PC4;
        state_d = pc_we ? S_FETCH : cls.jal ? S_WB : S_EXE;
      end
      S_EXE: begin
        alur_we = 1'b1;
        pc_we   = cls.beq;
        npc_op  = cls.beq ? NPC_BEQ : NPC_PC4;
        state_d = cls.beq ? S_FETCH : (cls.lw | cls.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // once the wait budget is spent the request drops and the instruction retires without write-back
        mem_read  = cls.lw & ~timeout;
        mem_write = cls.sw & ~timeout;
        pc_we     = timeout | (mem_ack & mem_write);
        state_d   = pc_we ? S_FETCH : (mem_ack & mem_read) ? S_WB : S_MEM;
        wcnt_d    = state_d == S_MEM ? wcnt_q + 1'b1 : '0;
        err_d     = err_q | (wcnt_d == WW'(MEM_TO));
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        npc_op    = cls.jal ? NPC_J : NPC_PC4;
      end
      default: ;
    endcase
    if (reset) begin
      ir_we     = 1'b0;
      ab_we     = 1'b0;
      alur_we   = 1'b0;
      pc_we     = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + CNT_W'(pc_we);
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream scored per retirement against a per-class path model
module tb_mc_ctrl;
  localparam int TO = 4;
  localparam int ADDU = 0, SUBU = 1, ORI = 2, LUI = 3, LW = 4, SW = 5, BEQ = 6, J = 7, JR = 8, JAL = 9, NOP = 10;
  logic clk = 1'b0, reset = 1'b1, mem_ack = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic [2:0] state, alu_ctrl;
  logic ir_we, ab_we, alur_we, pc_we, ext_op, reg_write, mem_read, mem_write, malub, mem_err;
  logic [1:0] npc_op, mgrf_a3, mgrf_wd;
  logic [15:0] retire_cnt;
  typedef struct {
    longint seq;
    int ncyc, nrd, nwr, nrw, nalu, cnt;
    logic [1:0] a3, wd, npc;
    logic [2:0] alu;
    logic malub, ext, err;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, ack_at = 0, m_cnt = 0;
  logic m_err = 1'b0;
  bit mon_en = 1'b0;
  mc_ctrl #(.CNT_W(16), .MEM_TO(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .mem_ack(mem_ack), .state(state),
    .ir_we(ir_we), .ab_we(ab_we), .alur_we(alur_we), .pc_we(pc_we), .npc_op(npc_op),
    .alu_ctrl(alu_ctrl), .ext_op(ext_op), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mgrf_a3(mgrf_a3), .mgrf_wd(mgrf_wd), .malub(malub),
    .mem_err(mem_err), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic set_ops(input int c);
    func = 6'($urandom);
    case (c)
      ADDU: {op, func} = {6'h00, 6'h21};
      SUBU: {op, func} = {6'h00, 6'h23};
      JR:   {op, func} = {6'h00, 6'h08};
      ORI:  op = 6'h0d;
      LUI:  op = 6'h0f;
      LW:   op = 6'h23;
      SW:   op = 6'h2b;
      BEQ:  op = 6'h04;
      J:    op = 6'h02;
      JAL:  op = 6'h03;
      default: if ($urandom_range(0, 1) == 1) op = 6'h3f; else {op, func} = {6'h00, 6'h00};
    endcase
  endtask
  // expected observable behaviour of one instruction, straight from its class path
  task automatic build(input int c, input int a, output exp_t e);
    int st[$];
    bit mem, ack;
    int mc;
    mem = c == LW || c == SW;
    ack = a >= 1 && a <= TO;
    mc  = ack ? a : TO + 1;
    e = '{default: 0};
    st = '{0, 1};
    if (!(c inside {J, JR, NOP, JAL})) st.push_back(2);
    if (mem) repeat (mc) st.push_back(3);
    if (c inside {ADDU, SUBU, ORI, LUI, JAL} || (c == LW && ack)) st.push_back(4);
    foreach (st[i]) e.seq = (e.seq << 3) | longint'(st[i]);
    e.ncyc  = st.size();
    e.nrd   = c == LW ? (ack ? a : TO) : 0;
    e.nwr   = c == SW ? (ack ? a : TO) : 0;
    e.nrw   = (c inside {ADDU, SUBU, ORI, LUI, JAL} || (c == LW && ack)) ? 1 : 0;
    e.nalu  = c inside {ADDU, SUBU, ORI, LUI, LW, SW, BEQ} ? 1 : 0;
    e.alu   = (c == SUBU || c == BEQ) ? 3'd1 : c == ORI ? 3'd2 : c == LUI ? 3'd3 : 3'd0;
    e.malub = c inside {ORI, LUI, LW, SW};
    e.ext   = c inside {LW, SW};
    e.a3    = c inside {ADDU, SUBU} ? 2'd1 : c == JAL ? 2'd2 : 2'd0;
    e.wd    = c == LW ? 2'd1 : c == JAL ? 2'd2 : 2'd0;
    e.npc   = c == BEQ ? 2'd1 : c inside {J, JAL} ? 2'd2 : c == JR ? 2'd3 : 2'd0;
    if (mem && !ack) m_err = 1'b1;
    e.err = m_err;
    e.cnt = m_cnt;
    m_cnt++;
  endtask
  task automatic issue(input int c, input int a);
    exp_t e;
    bit done;
    done = 1'b0;
    set_ops(c);
    ack_at = a;
    build(c, a, e);
    q.push_back(e);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = pc_we;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL retire_wait class=%0d actual=no_pc_we required=pc_we_within_40_cycles", c);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int mk;
    mk = 0;
    forever begin
      @(posedge clk);
      #1;
      if (state == 3'd3) begin
        mk++;
        mem_ack = mk == ack_at;
      end else begin
        mk = 0;
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end
  initial begin
    int ncyc, nrd, nwr, nrw, nalu, nir, nab;
    longint seq;
    logic [1:0] a3, wd;
    logic [2:0] alu;
    logic mb, ex;
    exp_t e;
    {ncyc, nrd, nwr, nrw, nalu, nir, nab} = '0;
    seq = 0; a3 = '0; wd = '0; alu = '0; mb = 1'b0; ex = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        ncyc++;
        seq = (seq << 3) | longint'(state);
        nir += int'(ir_we);
        nab += int'(ab_we);
        nrd += int'(mem_read);
        nwr += int'(mem_write);
        if (alur_we) begin nalu++; alu = alu_ctrl; mb = malub; ex = ext_op; end
        if (reg_write) begin nrw++; a3 = mgrf_a3; wd = mgrf_wd; end
        chk("rd_wr_excl", 64'(mem_read & mem_write), 0);
        chk("rw_wr_excl", 64'(reg_write & mem_write), 0);
        if (pc_we) begin
          chk("pending", q.size(), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("state_seq", seq, e.seq);
            chk("cycles", ncyc, e.ncyc);
            chk("ir_we_cycles", nir, 1);
            chk("ab_we_cycles", nab, 1);
            chk("mem_read_cycles", nrd, e.nrd);
            chk("mem_write_cycles", nwr, e.nwr);
            chk("reg_write_cycles", nrw, e.nrw);
            chk("alur_we_cycles", nalu, e.nalu);
            if (e.nrw > 0) begin chk("mgrf_a3", a3, e.a3); chk("mgrf_wd", wd, e.wd); end
            if (e.nalu > 0) begin chk("alu_ctrl", alu, e.alu); chk("malub", mb, e.malub); chk("ext_op", ex, e.ext); end
            chk("npc_op", npc_op, e.npc);
            chk("mem_err", mem_err, e.err);
            chk("retire_cnt", retire_cnt, e.cnt);
          end
          {ncyc, nrd, nwr, nrw, nalu, nir, nab} = '0;
          seq = 0;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bit hit;
    int c;
    hit = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    {op, func} = {6'h00, 6'h21};
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = state == 3'd2;
    end
    chk("reach_exe", 64'(hit), 1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("reset_strobes", {ir_we, ab_we, alur_we, pc_we, reg_write, mem_read, mem_write}, 0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_reset_state", state, 0);
    chk("post_reset_cnt", retire_cnt, 0);
    chk("post_reset_ir_we", 64'(ir_we), 1);
    chk("post_reset_err", 64'(mem_err), 0);
    mon_en = 1'b1;
    issue(ADDU, 0);
    issue(LW, 3);
    issue(SW, 1);
    issue(JAL, 0);
    issue(JR, 0);
    issue(LW, 0);
    issue(ADDU, 0);
    issue(SUBU, 0);
    issue(ORI, 0);
    issue(LUI, 0);
    issue(BEQ, 0);
    issue(J, 0);
    issue(NOP, 0);
    issue(SW, TO + 1);
    issue(LW, TO);
    for (int n = 0; n < 200; n++) begin
      c = $urandom_range(0, 10);
      issue(c, $urandom_range(0, TO + 1));
    end
    mon_en = 1'b0;
    @(negedge clk);
    chk("final_retire_cnt", retire_cnt, 64'(m_cnt));
    chk("final_mem_err", 64'(mem_err), 64'(m_err));
    chk("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that replaces the single-cycle combinational controller in the MIPS core.
- Sequences one shared datapath (PC, NPC, IR, GRF, ALU, EXT, DM, write-back muxes) through FETCH/DECODE/EXE/MEM/WB.
- Emits per-state register write strobes and mux selects.
- Runs a req/ack handshake with a variable-latency data memory and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TO, 16, max MEM-state wait cycles before the access is abandoned (min 1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; fixed
- op  in  6  IR[31:26], from registered IR; valid from DECODE onward
- func  in  6  IR[5:0], from registered IR
- mem_ack  in  1  DM completion; sampled only in MEM
- state  out  3  current FSM state (debug)
- ir_we  out  1  load IR from IM
- ab_we  out  1  latch GRF RD1/RD2 into A/B
- alur_we  out  1  latch ALU Result/Zero
- pc_we  out  1  PC <= NPC (retire strobe)
- npc_op  out  2  00 PC+4, 01 beq, 10 j/jal, 11 jr
- alu_ctrl  out  3  000 add, 001 sub, 010 or, 011 lui (B<<16)
- ext_op  out  1  0 zero-ext, 1 sign-ext
- reg_write  out  1  GRF write enable
- mem_read  out  1  DM read request
- mem_write  out  1  DM write request
- mgrf_a3  out  2  00 rt, 01 rd, 10 $31
- mgrf_wd  out  2  00 ALU result, 01 DM RD, 10 PC4
- malub  out  1  0 RD2, 1 Ext32
- mem_err  out  1  sticky; set on MEM timeout
- retire_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH next cycle with all strobes 0.
- Reset (sync):
  - state <= FETCH; retire_cnt <= 0; mem_err <= 0; wait counter <= 0.
  - While reset=1, every strobe (ir_we, ab_we, alur_we, pc_we, reg_write, mem_read, mem_write) is forced 0.
  - Mid-instruction reset abandons the instruction; no writes occur that cycle.
- Control outputs are combinational from state and decoded class (Moore per class). Selects not listed are 0.
- FETCH: ir_we=1; go to DECODE.
- DECODE: ab_we=1.
- Instruction classes and paths:
  - addu/subu: F,D,E,W. alu_ctrl 000/001, malub=0, mgrf_a3=01, wd=00.
  - ori: F,D,E,W. alu_ctrl=010, ext_op=0, malub=1, a3=00, wd=00.
  - lui: F,D,E,W. alu_ctrl=011, malub=1, a3=00, wd=00.
  - lw: F,D,E,M,W. ext_op=1, malub=1, alu_ctrl=000, mem_read in M, a3=00, wd=01.
  - sw: F,D,E,M. Same address path; mem_write in M; pc_we on the ack cycle.
  - beq: F,D,E. alu_ctrl=001, malub=0; pc_we and npc_op=01 in E (NPC uses live Zero).
  - j: F,D. pc_we, npc_op=10 in D.
  - jr: F,D. pc_we, npc_op=11 in D.
  - jal: F,D,W. In W: reg_write, a3=10, wd=10, pc_we, npc_op=10.
  - Undefined op/func: treated as nop. F,D with pc_we, npc_op=00 in D.
- EXE: alur_we=1.
- WB: reg_write=1 plus pc_we with npc_op=00, except jal.
- pc_we marks the last state of every instruction. The next state after pc_we is FETCH. retire_cnt increments on every pc_we and wraps at 2^CNT_W.
- MEM handshake:
  - mem_read/mem_write held high continuously until mem_ack=1 is sampled in MEM. Ack in the same cycle as the request is legal (1-cycle MEM).
  - mem_ack outside MEM is ignored.
  - The wait counter counts MEM cycles without ack. If it reaches MEM_TO, the request drops, mem_err <= 1, and the instruction retires with no GRF write (lw skips WB: pc_we=1 in MEM, npc_op=00).
  - The wait counter clears on leaving MEM.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.

Decomposition:
- Shared defines file mc_defs.v: state codes; opcode/func constants (R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011; addu=100001, subu=100011, jr=001000); NPCOp/ALUCtrl/MGRFA3/MGRFWD encodings.
- One sub-module, mc_decode: combinational op/func to one-hot class vector. mc_ctrl holds the FSM, wait counter, retire counter and output logic.

Test Plan:
- Reset held 3 cycles mid-EXE of addu: reset=1 -> all strobes 0 throughout. After release: state=0, retire_cnt=0, ir_we=1.
- addu (op 0, func 0x21): states 0,1,2,4. WB: reg_write=1, a3=01, wd=00, pc_we=1. retire_cnt 0->1.
- lw with mem_ack after 3 MEM cycles: mem_read=1 for exactly 3 cycles, then WB with wd=01, a3=00. 7 cycles total.
- sw with mem_ack in the first MEM cycle: mem_write=1 one cycle with pc_we=1 in the same cycle. reg_write never 1. Next state FETCH.
- jal then jr: jal is 3 cycles, W has a3=10, wd=10, npc_op=10. jr is 2 cycles, D has npc_op=11. retire_cnt +2.
- lw with mem_ack held 0 and MEM_TO=4: mem_read high 4 cycles, then mem_err=1, pc_we=1 and no reg_write. Next instruction runs normally with mem_err still 1.
